// File: rtl/entropy_src_window_stat.sv
// entropy_src_window_stat: per-window ones count with threshold fail pulses; optional ENTROPY_SRC_WIN_FAIL_CNT_EN builds the consecutive-fail counter
module entropy_src_window_stat #(
    parameter int RngBusWidth = 4,
    parameter int RegWidth    = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   clear_i,
    input  logic                   active_i,
    input  logic                   entropy_bit_vld_i,
    input  logic [RngBusWidth-1:0] entropy_bit_i,
    input  logic [RegWidth-1:0]    window_size_i,
    input  logic [RegWidth-1:0]    thresh_hi_i,
    input  logic [RegWidth-1:0]    thresh_lo_i,
    output logic [RegWidth-1:0]    test_cnt_o,
    output logic                   test_event_o,
    output logic                   test_fail_hi_pulse_o,
    output logic                   test_fail_lo_pulse_o,
    output logic [3:0]             fail_cnt_o
);
    logic [RegWidth-1:0] win_q, win_d, acc_q, acc_d, cnt_q, cnt_d, pop, sat;
    logic [RegWidth:0]   sum;
    logic                evt_q, evt_d, hi_q, hi_d, lo_q, lo_d;
    logic                run, idle, beat, win_end;

    assign run     = active_i && !clear_i;
    assign idle    = !run || (window_size_i == '0);
    assign beat    = !idle && entropy_bit_vld_i;
    assign win_end = beat && (win_q == window_size_i - RegWidth'(1));
    assign sum     = {1'b0, acc_q} + {1'b0, pop};
    assign sat     = sum[RegWidth] ? '1 : sum[RegWidth-1:0];

    // popcount of the current sample beat
    always_comb begin
        pop = '0;
        for (int i = 0; i < RngBusWidth; i++) pop = pop + RegWidth'(entropy_bit_i[i]);
    end

    // window progress, final count capture and end-of-window pulses
    always_comb begin
        win_d = (idle || win_end) ? '0 : beat ? win_q + RegWidth'(1) : win_q;
        acc_d = (idle || win_end) ? '0 : beat ? sat : acc_q;
        cnt_d = !run ? '0 : win_end ? sat : cnt_q;
        evt_d = win_end;
        hi_d  = win_end && (sat > thresh_hi_i);
        lo_d  = win_end && (sat < thresh_lo_i);
    end

    // state registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            win_q <= '0;
            acc_q <= '0;
            cnt_q <= '0;
            evt_q <= 1'b0;
            hi_q  <= 1'b0;
            lo_q  <= 1'b0;
        end else begin
            win_q <= win_d;
            acc_q <= acc_d;
            cnt_q <= cnt_d;
            evt_q <= evt_d;
            hi_q  <= hi_d;
            lo_q  <= lo_d;
        end
    end

    assign test_cnt_o           = cnt_q;
    assign test_event_o         = evt_q;
    assign test_fail_hi_pulse_o = hi_q;
    assign test_fail_lo_pulse_o = lo_q;

`ifdef ENTROPY_SRC_WIN_FAIL_CNT_EN
    logic [3:0] fc_q, fc_d;

    // consecutive failing windows, saturating; a passing window end clears it
    always_comb begin
        fc_d = !run ? 4'd0 :
               !win_end ? fc_q :
               (hi_d || lo_d) ? ((fc_q == 4'hf) ? fc_q : fc_q + 4'd1) : 4'd0;
    end

    // fail counter register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) fc_q <= 4'd0;
        else         fc_q <= fc_d;
    end

    assign fail_cnt_o = fc_q;
`else
    assign fail_cnt_o = 4'd0;
`endif
endmodule

// File: tb/tb_entropy_src_window_stat.sv
// tb_entropy_src_window_stat: directed self-checking bench for entropy_src_window_stat
module tb_entropy_src_window_stat;
`ifdef ENTROPY_SRC_WIN_FAIL_CNT_EN
    localparam bit FcEn = 1'b1;
`else
    localparam bit FcEn = 1'b0;
`endif
    logic        clk = 1'b0, rst_n = 1'b0, clear = 1'b0, active = 1'b0, vld = 1'b0;
    logic [3:0]  bits = 4'd0;
    logic [15:0] ws = '0, thi = 16'hffff, tlo = '0;
    logic [3:0]  ws4 = '0, thi4 = 4'hf, tlo4 = '0;
    logic [15:0] cnt;
    logic [3:0]  cnt4, fc, fc4;
    logic        evt, fhi, flo, evt4, fhi4, flo4;
    int          tests = 0, fails = 0;

    always #5 clk = ~clk;

    entropy_src_window_stat dut (
        .clk_i(clk), .rst_ni(rst_n), .clear_i(clear), .active_i(active),
        .entropy_bit_vld_i(vld), .entropy_bit_i(bits), .window_size_i(ws),
        .thresh_hi_i(thi), .thresh_lo_i(tlo), .test_cnt_o(cnt), .test_event_o(evt),
        .test_fail_hi_pulse_o(fhi), .test_fail_lo_pulse_o(flo), .fail_cnt_o(fc)
    );

    entropy_src_window_stat #(.RngBusWidth(4), .RegWidth(4)) dut4 (
        .clk_i(clk), .rst_ni(rst_n), .clear_i(clear), .active_i(active),
        .entropy_bit_vld_i(vld), .entropy_bit_i(bits), .window_size_i(ws4),
        .thresh_hi_i(thi4), .thresh_lo_i(tlo4), .test_cnt_o(cnt4), .test_event_o(evt4),
        .test_fail_hi_pulse_o(fhi4), .test_fail_lo_pulse_o(flo4), .fail_cnt_o(fc4)
    );

    task automatic beat(input logic v, input logic [3:0] b);
        vld  = v;
        bits = b;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        active = 1'b1;
        vld = 1'b1;
        bits = 4'hf;
        ws = 16'd1;
        repeat (3) @(posedge clk);
        #1;
        tests++; if (cnt !== 16'd0) begin fails++; $display("FAIL reset_cnt got %0d exp 0", cnt); end
        tests++; if ({evt, fhi, flo} !== 3'b000) begin fails++; $display("FAIL reset_pulses got %b exp 000", {evt, fhi, flo}); end
        tests++; if (fc !== 4'd0) begin fails++; $display("FAIL reset_fc got %0d exp 0", fc); end
        vld = 1'b0;
        ws = '0;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic();
        ws = 16'd4; thi = 16'd11; tlo = 16'd2;
        for (int i = 0; i < 3; i++) begin
            beat(1'b1, 4'b1011);
            tests++; if (evt !== 1'b0) begin fails++; $display("FAIL basic_early_evt beat %0d got %b exp 0", i, evt); end
        end
        beat(1'b1, 4'b1011);
        tests++; if (evt !== 1'b1) begin fails++; $display("FAIL basic_evt got %b exp 1", evt); end
        tests++; if (cnt !== 16'd12) begin fails++; $display("FAIL basic_cnt got %0d exp 12", cnt); end
        tests++; if ({fhi, flo} !== 2'b10) begin fails++; $display("FAIL basic_fail got %b exp 10", {fhi, flo}); end
        beat(1'b0, 4'b0000);
        tests++; if ({evt, fhi} !== 2'b00) begin fails++; $display("FAIL basic_one_cycle got %b exp 00", {evt, fhi}); end
        tests++; if (cnt !== 16'd12) begin fails++; $display("FAIL basic_hold got %0d exp 12", cnt); end
    endtask

    task automatic test_back_to_back();
        logic [3:0]  pat [3] = '{4'b0000, 4'b1111, 4'b0001};
        logic [15:0] ec  [3] = '{16'd0, 16'd4, 16'd1};
        logic        el  [3] = '{1'b1, 1'b0, 1'b0};
        ws = 16'd1; thi = 16'd15; tlo = 16'd1;
        for (int i = 0; i < 3; i++) begin
            beat(1'b1, pat[i]);
            tests++; if (evt !== 1'b1) begin fails++; $display("FAIL b2b_evt %0d got %b exp 1", i, evt); end
            tests++; if (cnt !== ec[i]) begin fails++; $display("FAIL b2b_cnt %0d got %0d exp %0d", i, cnt, ec[i]); end
            tests++; if ({fhi, flo} !== {1'b0, el[i]}) begin fails++; $display("FAIL b2b_fail %0d got %b exp %b", i, {fhi, flo}, {1'b0, el[i]}); end
        end
        beat(1'b0, 4'b0000);
    endtask

    task automatic test_clear();
        ws = 16'd8; thi = 16'd15; tlo = 16'd0;
        repeat (5) beat(1'b1, 4'b0001);
        clear = 1'b1;
        beat(1'b1, 4'b0001);
        clear = 1'b0;
        tests++; if (evt !== 1'b0) begin fails++; $display("FAIL clear_evt got %b exp 0", evt); end
        tests++; if (cnt !== 16'd0) begin fails++; $display("FAIL clear_cnt got %0d exp 0", cnt); end
        for (int i = 0; i < 7; i++) begin
            beat(1'b1, 4'b0001);
            tests++; if (evt !== 1'b0) begin fails++; $display("FAIL clear_early_evt beat %0d got %b exp 0", i, evt); end
        end
        beat(1'b1, 4'b0001);
        tests++; if (evt !== 1'b1 || cnt !== 16'd8) begin fails++; $display("FAIL clear_window got evt %b cnt %0d exp evt 1 cnt 8", evt, cnt); end
        beat(1'b0, 4'b0000);
    endtask

    task automatic test_inactive();
        ws = 16'd2;
        beat(1'b1, 4'b1111);
        active = 1'b0;
        beat(1'b1, 4'b1111);
        tests++; if (evt !== 1'b0 || cnt !== 16'd0) begin fails++; $display("FAIL inactive got evt %b cnt %0d exp evt 0 cnt 0", evt, cnt); end
        active = 1'b1;
        beat(1'b1, 4'b0011);
        tests++; if (evt !== 1'b0) begin fails++; $display("FAIL inactive_discard got evt %b exp 0", evt); end
        beat(1'b1, 4'b0001);
        tests++; if (evt !== 1'b1 || cnt !== 16'd3) begin fails++; $display("FAIL inactive_resume got evt %b cnt %0d exp evt 1 cnt 3", evt, cnt); end
        beat(1'b0, 4'b0000);
    endtask

    task automatic test_gapped();
        ws = 16'd3;
        for (int i = 0; i < 3; i++) begin
            beat(1'b1, 4'b1111);
            if (i == 2) begin
                tests++; if (evt !== 1'b1 || cnt !== 16'd12) begin fails++; $display("FAIL gap_window got evt %b cnt %0d exp evt 1 cnt 12", evt, cnt); end
            end else begin
                tests++; if (evt !== 1'b0) begin fails++; $display("FAIL gap_early_evt %0d got %b exp 0", i, evt); end
            end
            for (int j = 0; j < 2; j++) begin
                beat(1'b0, 4'b1111);
                tests++; if (evt !== 1'b0) begin fails++; $display("FAIL gap_idle_evt %0d.%0d got %b exp 0", i, j, evt); end
            end
        end
    endtask

    task automatic test_saturate_and_disable();
        int ev = 0, ev4 = 0;
        ws = 16'd0; ws4 = 4'd8; thi4 = 4'hf; tlo4 = 4'd0;
        for (int i = 0; i < 7; i++) beat(1'b1, 4'b1111);
        tests++; if (evt4 !== 1'b0) begin fails++; $display("FAIL sat_early_evt got %b exp 0", evt4); end
        beat(1'b1, 4'b1111);
        tests++; if (evt4 !== 1'b1 || cnt4 !== 4'd15) begin fails++; $display("FAIL sat_window got evt %b cnt %0d exp evt 1 cnt 15", evt4, cnt4); end
        tests++; if ({fhi4, flo4} !== 2'b00) begin fails++; $display("FAIL sat_fail got %b exp 00", {fhi4, flo4}); end
        ws4 = 4'd0;
        for (int i = 0; i < 100; i++) begin
            beat(1'b1, 4'b1111);
            ev += int'(evt);
            ev4 += int'(evt4);
        end
        tests++; if (ev !== 0 || ev4 !== 0) begin fails++; $display("FAIL ws0_events got %0d/%0d exp 0/0", ev, ev4); end
        tests++; if (cnt4 !== 4'd15 || cnt !== 16'd12) begin fails++; $display("FAIL ws0_hold got %0d/%0d exp 15/12", cnt4, cnt); end
        beat(1'b0, 4'b0000);
    endtask

    task automatic test_fail_cnt();
        logic [3:0] exp;
        ws = 16'd1; thi = 16'd0; tlo = 16'd0;
        for (int k = 1; k <= 17; k++) begin
            beat(1'b1, 4'b0001);
            exp = FcEn ? ((k > 15) ? 4'd15 : 4'(k)) : 4'd0;
            tests++; if (fc !== exp) begin fails++; $display("FAIL fail_cnt window %0d got %0d exp %0d", k, fc, exp); end
        end
        tests++; if (fhi !== 1'b1) begin fails++; $display("FAIL fail_cnt_hi got %b exp 1", fhi); end
        beat(1'b1, 4'b0000);
        tests++; if (fc !== 4'd0 || fhi !== 1'b0) begin fails++; $display("FAIL fail_cnt_pass got fc %0d hi %b exp fc 0 hi 0", fc, fhi); end
        beat(1'b0, 4'b0000);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_clear();
        test_inactive();
        test_gapped();
        test_saturate_and_disable();
        test_fail_cnt();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
